// File: rtl/us_ping_scheduler_pkg.sv
// Shared definitions for the ultrasonic ranger scheduler: slot states,
// sensor indices, distance codes and the round-robin selection helper.
package us_ping_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_ECHO,
    ST_ECHO,
    ST_GUARD
  } state_t;

  localparam int unsigned NUM_SENSORS = 4;

  localparam logic [1:0] SIDE_BACK  = 2'd0;
  localparam logic [1:0] SIDE_FRONT = 2'd1;
  localparam logic [1:0] FRONT      = 2'd2;
  localparam logic [1:0] BACK       = 2'd3;

  localparam logic [7:0] DIST_NONE = 8'hFF;
  localparam logic [7:0] DIST_SAT  = 8'hFE;

  // Nearest set mask bit after cur in 0->1->2->3->0 order. When incl_cur is
  // set, cur itself has top priority; otherwise it is the last resort, which
  // is what lets a lone sensor repeat back to back.
  function automatic logic [1:0] next_sensor(input logic [1:0] cur,
                                             input logic [3:0] mask,
                                             input logic       incl_cur);
    logic [1:0] pick;
    logic [1:0] off;
    logic [1:0] cand;
    pick = cur;
    if (!incl_cur && mask[cur]) pick = cur;
    for (int unsigned k = 0; k < 3; k++) begin
      off  = 2'(3 - k);
      cand = cur + off;
      if (mask[cand]) pick = cand;
    end
    if (incl_cur && mask[cur]) pick = cur;
    return pick;
  endfunction

endpackage

// File: rtl/us_ping_scheduler_if.sv
// Control, pad and result bundle of the ultrasonic ranger scheduler.
interface us_ping_scheduler_if;
  import us_ping_scheduler_pkg::*;

  logic                         enable;
  logic [NUM_SENSORS-1:0]       sensor_mask;
  logic [NUM_SENSORS-1:0]       sig_in;
  logic [NUM_SENSORS-1:0]       sig_out;
  logic [NUM_SENSORS-1:0]       sig_oe;
  logic [8*NUM_SENSORS-1:0]     distance;
  logic [NUM_SENSORS-1:0]       valid;
  logic [NUM_SENSORS-1:0]       timeout;
  logic [1:0]                   active;
  logic                         busy;

  modport master (
    input  enable, sensor_mask, sig_in,
    output sig_out, sig_oe, distance, valid, timeout, active, busy
  );

  modport slave (
    output enable, sensor_mask, sig_in,
    input  sig_out, sig_oe, distance, valid, timeout, active, busy
  );
endinterface

// File: rtl/us_tick_gen.sv
// Free-running 1 us tick prescaler; at 1 MHz the tick is high every cycle.
module us_tick_gen #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int unsigned DIV  = (CLK_HZ / 1_000_000 > 1) ? CLK_HZ / 1_000_000 : 1;
  localparam int unsigned CW   = $clog2(DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/us_ping_scheduler.sv
// Round-robin scheduler for four single-pin ultrasonic rangers: triggers one
// sensor per slot, measures its echo in centimetres and publishes the result.
module us_ping_scheduler
  import us_ping_scheduler_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned TRIG_US       = 5,
  parameter int unsigned ECHO_START_US = 1000,
  parameter int unsigned ECHO_MAX_US   = 18500,
  parameter int unsigned GUARD_US      = 10000,
  parameter int unsigned US_PER_CM     = 58
) (
  input  logic                 clk,
  input  logic                 rst_n,
  us_ping_scheduler_if.master  bus
);
  localparam int unsigned T1   = (ECHO_MAX_US > GUARD_US) ? ECHO_MAX_US : GUARD_US;
  localparam int unsigned T2   = (T1 > ECHO_START_US) ? T1 : ECHO_START_US;
  localparam int unsigned TMAX = (T2 > TRIG_US) ? T2 : TRIG_US;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned SW   = $clog2(US_PER_CM + 1);

  localparam logic [TW-1:0] TRIG_LAST  = TW'(TRIG_US - 1);
  localparam logic [TW-1:0] START_LAST = TW'(ECHO_START_US - 1);
  localparam logic [TW-1:0] ECHO_LIMIT = TW'(ECHO_MAX_US);
  localparam logic [TW-1:0] GUARD_LAST = TW'(GUARD_US - 1);
  localparam logic [SW-1:0] SUB_LAST   = SW'(US_PER_CM - 1);

  logic                   tick;
  logic [3:0]             sig_meta;
  logic [3:0]             sig_sync;
  logic                   echo;
  state_t                 state;
  logic [TW-1:0]          timer;
  logic [SW-1:0]          sub;
  logic [7:0]             cm;
  logic                   first_slot;
  logic [1:0]             next_sel;
  logic [3:0]             sel_onehot;

  us_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_meta <= '0;
      sig_sync <= '0;
    end else begin
      sig_meta <= bus.sig_in;
      sig_sync <= sig_meta;
    end
  end

  // The first slot after reset starts at sensor 0 itself; later slots move on.
  always_comb begin
    echo       = sig_sync[bus.active];
    next_sel   = next_sensor(bus.active, bus.sensor_mask, first_slot);
    sel_onehot = 4'b0001 << next_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      timer       <= '0;
      sub         <= '0;
      cm          <= '0;
      first_slot  <= 1'b1;
      bus.sig_out <= '0;
      bus.sig_oe  <= '0;
      bus.distance <= '1;
      bus.valid   <= '0;
      bus.timeout <= '0;
      bus.active  <= SIDE_BACK;
      bus.busy    <= 1'b0;
    end else begin
      bus.valid <= '0;
      case (state)
        ST_IDLE: begin
          if (bus.enable && bus.sensor_mask != '0) begin
            state       <= ST_TRIG;
            timer       <= '0;
            first_slot  <= 1'b0;
            bus.active  <= next_sel;
            bus.sig_oe  <= sel_onehot;
            bus.sig_out <= sel_onehot;
            bus.busy    <= 1'b1;
          end
        end
        ST_TRIG: begin
          if (tick) begin
            if (timer == TRIG_LAST) begin
              state       <= ST_WAIT_ECHO;
              timer       <= '0;
              bus.sig_oe  <= '0;
              bus.sig_out <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        ST_WAIT_ECHO: begin
          if (echo) begin
            // The cycle the rise is seen already counts as the first echo tick.
            state <= ST_ECHO;
            cm    <= '0;
            timer <= TW'(tick);
            sub   <= SW'(tick);
          end else if (tick) begin
            if (timer == START_LAST) begin
              state <= ST_GUARD;
              timer <= '0;
              bus.distance[bus.active*8 +: 8] <= DIST_NONE;
              bus.timeout[bus.active] <= 1'b1;
              bus.valid[bus.active]   <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        ST_ECHO: begin
          if (!echo) begin
            state <= ST_GUARD;
            timer <= '0;
            bus.distance[bus.active*8 +: 8] <= cm;
            bus.timeout[bus.active] <= 1'b0;
            bus.valid[bus.active]   <= 1'b1;
          end else if (tick) begin
            if (timer == ECHO_LIMIT) begin
              state <= ST_GUARD;
              timer <= '0;
              bus.distance[bus.active*8 +: 8] <= DIST_NONE;
              bus.timeout[bus.active] <= 1'b1;
              bus.valid[bus.active]   <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
              if (sub == SUB_LAST) begin
                sub <= '0;
                if (cm != DIST_SAT) cm <= cm + 1'b1;
              end else begin
                sub <= sub + 1'b1;
              end
            end
          end
        end
        ST_GUARD: begin
          if (tick) begin
            if (timer == GUARD_LAST) begin
              timer <= '0;
              if (bus.enable && bus.sensor_mask != '0) begin
                state       <= ST_TRIG;
                bus.active  <= next_sel;
                bus.sig_oe  <= sel_onehot;
                bus.sig_out <= sel_onehot;
              end else begin
                state    <= ST_IDLE;
                bus.busy <= 1'b0;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        default: begin
          state       <= ST_IDLE;
          bus.sig_oe  <= '0;
          bus.sig_out <= '0;
          bus.busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_us_ping_scheduler.sv
// Directed bench for us_ping_scheduler: one-cycle tick, scaled timing, and a
// sensor model that answers each trigger with a programmable echo.
module tb_us_ping_scheduler;

  localparam int TRIG  = 5;
  localparam int START = 100;
  localparam int EMAX  = 1100;
  localparam int GUARD = 50;
  localparam int UPC   = 4;
  localparam int NVEC  = 18;

  typedef struct {
    logic [3:0]  mask;
    int          len;
    logic [1:0]  exp_act;
    logic [7:0]  exp_d;
    logic        exp_to;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   cyc;
  int   fall_cyc;
  int   echo_len;

  us_ping_scheduler_if bus ();

  us_ping_scheduler #(
    .CLK_HZ        (1_000_000),
    .TRIG_US       (TRIG),
    .ECHO_START_US (START),
    .ECHO_MAX_US   (EMAX),
    .GUARD_US      (GUARD),
    .US_PER_CM     (UPC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Sensor model and trigger monitor, sampled 1 time unit after each edge.
  initial begin
    logic [3:0] prev_oe;
    logic [1:0] pin;
    logic       high;
    logic       shape_ok;
    int         delay;
    int         rem;
    int         run;
    bus.sig_in = '0;
    prev_oe = '0; pin = '0; high = 1'b0; shape_ok = 1'b1;
    delay = 0; rem = 0; run = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.sig_oe != '0) begin
        run++;
        if ($countones(bus.sig_oe) != 1 || bus.sig_out != bus.sig_oe) shape_ok = 1'b0;
      end
      if (prev_oe != '0 && bus.sig_oe == '0) begin
        fall_cyc = cyc;
        if (rst_n) begin
          check("trig_width", run, TRIG);
          check("trig_shape", 32'(shape_ok), 1);
        end
        for (int i = 0; i < 4; i++) if (prev_oe[i]) pin = 2'(i);
        if (echo_len > 0 && !high) begin
          delay = 3;
          rem   = echo_len;
        end
        run = 0;
        shape_ok = 1'b1;
      end else if (high) begin
        rem--;
        if (rem == 0) begin
          bus.sig_in[pin] = 1'b0;
          high = 1'b0;
        end
      end else if (delay > 0) begin
        delay--;
        if (delay == 0) begin
          bus.sig_in[pin] = 1'b1;
          high = 1'b1;
        end
      end
      prev_oe = bus.sig_oe;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       vecs [NVEC];
    logic [7:0] exp_d [4];
    logic [3:0] exp_t;
    logic [3:0] oh;
    int         c;
    int         exp_lat;

    vecs[0]  = '{4'hF,   40, 2'd0, 8'd10,  1'b0};
    vecs[1]  = '{4'hF,   40, 2'd1, 8'd10,  1'b0};
    vecs[2]  = '{4'hF,   40, 2'd2, 8'd10,  1'b0};
    vecs[3]  = '{4'hF,   40, 2'd3, 8'd10,  1'b0};
    vecs[4]  = '{4'hF,   40, 2'd0, 8'd10,  1'b0};
    vecs[5]  = '{4'hF,   40, 2'd1, 8'd10,  1'b0};
    vecs[6]  = '{4'hF,    0, 2'd2, 8'hFF,  1'b1};
    vecs[7]  = '{4'hF,   40, 2'd3, 8'd10,  1'b0};
    vecs[8]  = '{4'h2, 1140, 2'd1, 8'hFF,  1'b1};
    vecs[9]  = '{4'h2,    8, 2'd1, 8'd2,   1'b0};
    vecs[10] = '{4'h2, 1012, 2'd1, 8'hFD,  1'b0};
    vecs[11] = '{4'h2, 1020, 2'd1, 8'hFE,  1'b0};
    vecs[12] = '{4'h2, 1100, 2'd1, 8'hFE,  1'b0};
    vecs[13] = '{4'h2, 1101, 2'd1, 8'hFF,  1'b1};
    vecs[14] = '{4'h5,   40, 2'd2, 8'd10,  1'b0};
    vecs[15] = '{4'h5,   20, 2'd0, 8'd5,   1'b0};
    vecs[16] = '{4'h5,   24, 2'd2, 8'd6,   1'b0};
    vecs[17] = '{4'h5,   40, 2'd0, 8'd10,  1'b0};

    n_cmp = 0; n_bad = 0; cyc = 0; fall_cyc = 0; echo_len = 0;
    rst_n = 1'b0;
    bus.enable = 1'b0;
    bus.sensor_mask = '0;
    for (int i = 0; i < 4; i++) exp_d[i] = 8'hFF;
    exp_t = '0;

    repeat (3) step();
    check("rst_sig_out", bus.sig_out, 0);
    check("rst_sig_oe", bus.sig_oe, 0);
    check("rst_distance", bus.distance, 32'hFFFF_FFFF);
    check("rst_valid", bus.valid, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_active", bus.active, 0);
    check("rst_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < NVEC; v++) begin
      bus.sensor_mask = vecs[v].mask;
      echo_len = vecs[v].len;
      bus.enable = 1'b1;
      c = 0;
      while (bus.valid == '0 && c < 5000) begin
        step();
        c++;
      end
      if (c == 5000) check("valid_wait", 0, 1);
      exp_d[vecs[v].exp_act] = vecs[v].exp_d;
      exp_t[vecs[v].exp_act] = vecs[v].exp_to;
      oh = 4'b0001 << vecs[v].exp_act;
      if (vecs[v].len == 0) exp_lat = START;
      else if (vecs[v].len > EMAX) exp_lat = EMAX + 6;
      else exp_lat = vecs[v].len + 6;
      check($sformatf("v%0d_active", v), bus.active, vecs[v].exp_act);
      check($sformatf("v%0d_valid", v), bus.valid, oh);
      check($sformatf("v%0d_distance", v), bus.distance, {exp_d[3], exp_d[2], exp_d[1], exp_d[0]});
      check($sformatf("v%0d_timeout", v), bus.timeout, exp_t);
      check($sformatf("v%0d_latency", v), cyc - fall_cyc, exp_lat);
      check($sformatf("v%0d_busy", v), bus.busy, 1);
      step();
      check($sformatf("v%0d_valid_pulse", v), bus.valid, 0);
    end

    // Mask cleared mid-slot: the slot and its guard finish, then IDLE.
    echo_len = 40;
    c = 0;
    while (bus.sig_oe == '0 && c < 500) begin step(); c++; end
    check("mid_oe", bus.sig_oe, 4'b0100);
    bus.sensor_mask = '0;
    c = 0;
    while (bus.valid == '0 && c < 500) begin step(); c++; end
    exp_d[2] = 8'd10;
    check("mid_valid", bus.valid, 4'b0100);
    check("mid_distance", bus.distance, {exp_d[3], exp_d[2], exp_d[1], exp_d[0]});
    repeat (GUARD - 1) step();
    check("mid_guard_busy", bus.busy, 1);
    step();
    check("mid_idle_busy", bus.busy, 0);
    repeat (20) step();
    check("mid_idle_oe", bus.sig_oe, 0);
    check("mid_idle_busy2", bus.busy, 0);

    // Restart from IDLE: the next set bit after the last active sensor.
    echo_len = 500;
    bus.sensor_mask = 4'b1000;
    c = 0;
    while (bus.sig_oe == '0 && c < 50) begin step(); c++; end
    check("idle_next_oe", bus.sig_oe, 4'b1000);
    c = 0;
    while (bus.sig_oe != '0 && c < 50) begin step(); c++; end
    repeat (30) step();
    check("pre_rst_busy", bus.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("echo_rst_oe", bus.sig_oe, 0);
    check("echo_rst_out", bus.sig_out, 0);
    check("echo_rst_distance", bus.distance, 32'hFFFF_FFFF);
    check("echo_rst_valid", bus.valid, 0);
    check("echo_rst_timeout", bus.timeout, 0);
    check("echo_rst_active", bus.active, 0);
    check("echo_rst_busy", bus.busy, 0);
    bus.enable = 1'b0;
    c = 0;
    while (bus.sig_in != '0 && c < 1000) begin step(); c++; end
    check("echo_drained", bus.sig_in, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.sensor_mask = 4'hF;
    bus.enable = 1'b1;
    step();
    c = 0;
    while (bus.sig_oe == '0 && c < 50) begin step(); c++; end
    check("post_rst_first_oe", bus.sig_oe, 4'b0001);

    // Reset while the trigger is being driven releases the pad at once.
    step();
    check("trig_oe_held", bus.sig_oe, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("trig_rst_oe", bus.sig_oe, 0);
    check("trig_rst_busy", bus.busy, 0);
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
